// File: rtl/i2c_prog_master.sv
// rtl/i2c_prog_master.sv - single-byte I2C write master, quarter-tick bit timing.
// Define I2C_MASTER_READ_EN to allow rw=1 single-byte reads into rdata.
module i2c_prog_master #(
    parameter int CLK_DIV = 250
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic [7:0] rdata,
    output logic       scl_o,
    output logic       sda_o,
    output logic       sda_oe,
    input  logic       sda_i
);
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_ADDR, S_ACK1, S_DATA, S_ACK2, S_STOP
    } state_t;

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  qtr_q, qtr_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  sh_q, sh_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        rd_q, rd_d;
    logic        ack_err_q, ack_err_d;
    logic        done_q, done_d;
    logic        rw_eff;
    logic        tick, slot_end, sample;

`ifdef I2C_MASTER_READ_EN
    assign rw_eff = rw;
`else
    logic unused_rw;
    assign unused_rw = rw;
    assign rw_eff    = 1'b0;
`endif

    assign tick     = (cnt_q == DIV_LAST);
    assign slot_end = tick && (qtr_q == 2'd3);
    // SDA is sampled on the edge where SCL rises (q1 -> q2)
    assign sample   = tick && (qtr_q == 2'd1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        qtr_d     = qtr_q;
        bit_d     = bit_q;
        sh_d      = sh_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        rd_d      = rd_q;
        ack_err_d = ack_err_q;
        done_d    = 1'b0;
        if (state_q == S_IDLE) begin
            cnt_d = 16'd0;
            qtr_d = 2'd0;
            bit_d = 3'd0;
            // done_q blocks a start coinciding with the done pulse
            if (start && !done_q) begin
                state_d   = S_START;
                sh_d      = {addr, rw_eff};
                wdata_d   = wdata;
                rd_d      = rw_eff;
                ack_err_d = 1'b0;
            end
        end else begin
            cnt_d = tick ? 16'd0 : cnt_q + 16'd1;
            if (tick) qtr_d = qtr_q + 2'd1;
            case (state_q)
                S_ACK1:  if (sample && sda_i) ack_err_d = 1'b1;
                S_ACK2:  if (sample && sda_i && !rd_q) ack_err_d = 1'b1;
                S_DATA:  if (sample && rd_q) sh_d = {sh_q[6:0], sda_i};
                default: ;
            endcase
            if (slot_end) begin
                case (state_q)
                    S_START: state_d = S_ADDR;
                    S_ADDR: begin
                        sh_d  = {sh_q[6:0], 1'b0};
                        bit_d = bit_q + 3'd1;
                        if (bit_q == 3'd7) state_d = S_ACK1;
                    end
                    S_ACK1: begin
                        if (ack_err_q) begin
                            state_d = S_STOP;
                        end else begin
                            state_d = S_DATA;
                            sh_d    = wdata_q;
                        end
                    end
                    S_DATA: begin
                        if (!rd_q) sh_d = {sh_q[6:0], 1'b0};
                        bit_d = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            state_d = S_ACK2;
`ifdef I2C_MASTER_READ_EN
                            if (rd_q) rdata_d = sh_q;
`endif
                        end
                    end
                    S_ACK2:  state_d = S_STOP;
                    S_STOP: begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        scl_o  = 1'b1;
        sda_oe = 1'b0;
        case (state_q)
            S_START: begin
                scl_o  = (qtr_q != 2'd3);
                sda_oe = qtr_q[1];
            end
            S_ADDR: begin
                scl_o  = qtr_q[1];
                sda_oe = ~sh_q[7];
            end
            S_DATA: begin
                scl_o  = qtr_q[1];
                sda_oe = rd_q ? 1'b0 : ~sh_q[7];
            end
            S_ACK1, S_ACK2: scl_o = qtr_q[1];
            S_STOP: begin
                scl_o  = qtr_q[1];
                sda_oe = (qtr_q != 2'd3);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= 16'd0;
            qtr_q     <= 2'd0;
            bit_q     <= 3'd0;
            sh_q      <= 8'h00;
            wdata_q   <= 8'h00;
            rdata_q   <= 8'h00;
            rd_q      <= 1'b0;
            ack_err_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            qtr_q     <= qtr_d;
            bit_q     <= bit_d;
            sh_q      <= sh_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            rd_q      <= rd_d;
            ack_err_q <= ack_err_d;
            done_q    <= done_d;
        end
    end

    assign busy    = (state_q != S_IDLE);
    assign done    = done_q;
    assign ack_err = ack_err_q;
    assign rdata   = rdata_q;
    assign sda_o   = 1'b0;
endmodule

// File: tb/tb_i2c_prog_master.sv
// tb/tb_i2c_prog_master.sv - directed bench for i2c_prog_master (CLK_DIV=4 and CLK_DIV=1).
module tb_i2c_prog_master;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start4, start1, rw, sda_i4, sda_i1;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic       busy4, done4, ack_err4, scl4, sdao4, oe4;
    logic       busy1, done1, ack_err1, scl1, sdao1, oe1;
    logic [7:0] rdata4, rdata1;

    assign sda_i1 = 1'b0;

    i2c_prog_master #(.CLK_DIV(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .rw(rw), .addr(addr), .wdata(wdata),
        .busy(busy4), .done(done4), .ack_err(ack_err4), .rdata(rdata4),
        .scl_o(scl4), .sda_o(sdao4), .sda_oe(oe4), .sda_i(sda_i4));

    i2c_prog_master #(.CLK_DIV(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .rw(rw), .addr(addr), .wdata(wdata),
        .busy(busy1), .done(done1), .ack_err(ack_err1), .rdata(rdata1),
        .scl_o(scl1), .sda_o(sdao1), .sda_oe(oe1), .sda_i(sda_i1));

    int n_tests = 0;
    int n_fail  = 0;

    // Responder: records the bus level at each SCL rise, drives ACK/read bits while SCL is low
    bit          clr = 1'b0;
    bit          ack_en, rd_mode;
    logic [7:0]  rd_byte;
    int          rise_cnt;
    int          nn;
    logic [31:0] cap;

    always @(posedge scl4 or negedge scl4 or posedge clr) begin
        if (clr) begin
            rise_cnt = 0;
            cap      = 32'h0;
            sda_i4   = 1'b1;
        end else if (scl4) begin
            rise_cnt = rise_cnt + 1;
            cap      = {cap[30:0], (oe4 ? 1'b0 : sda_i4)};
        end else begin
            nn     = rise_cnt + 1;
            sda_i4 = 1'b1;
            if (nn == 9 && ack_en) sda_i4 = 1'b0;
            if (nn >= 10 && nn <= 17 && rd_mode) sda_i4 = rd_byte[17 - nn];
            if (nn == 18 && ack_en && !rd_mode) sda_i4 = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    int           done_e4, done_e1, ndone4, ndone1;
    logic [159:0] tr4, tr1;

    task automatic run(input bit with1, input int ign_at, input int rst_at);
        int poke;
        poke    = -1;
        done_e4 = -1;
        done_e1 = -1;
        ndone4  = 0;
        ndone1  = 0;
        tr4     = '0;
        tr1     = '0;
        @(negedge clk);
        clr = 1'b1;
        #1 clr = 1'b0;
        chk("busy_before_start", busy4, 0);
        start4 = 1'b1;
        if (with1) start1 = 1'b1;
        for (int e = 0; e < 400; e++) begin
            @(negedge clk);
            if (e == 0) begin
                start4 = 1'b0;
                start1 = 1'b0;
                chk("busy_after_accept", busy4, 1);
                chk("ack_err_cleared_on_accept", ack_err4, 0);
            end
            if (e < 80) tr1[2*e +: 2] = {scl1, oe1};
            if (e < 320 && (e % 4) == 0) tr4[2*(e/4) +: 2] = {scl4, oe4};
            if (done1) begin
                ndone1++;
                if (done_e1 < 0) done_e1 = e;
            end
            if (poke >= 0 && e == poke + 1) begin
                start4 = 1'b0;
                chk("start_during_done_ignored", busy4, 0);
            end
            if (done4) begin
                ndone4++;
                if (done_e4 < 0) begin
                    done_e4 = e;
                    chk("busy_falls_with_done", busy4, 0);
                    start4 = 1'b1;
                    poke   = e;
                end
            end
            if (ign_at >= 0 && e == ign_at) begin
                start4 = 1'b1;
                addr   = 7'h11;
                wdata  = 8'h00;
            end
            if (ign_at >= 0 && e == ign_at + 1) start4 = 1'b0;
            if (rst_at >= 0 && e == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_scl_high", scl4, 1);
                chk("rst_sda_released", oe4, 0);
                chk("rst_busy_low", busy4, 0);
                chk("rst_done_low", done4, 0);
            end
            if (rst_at >= 0 && e == rst_at + 3) rst_n = 1'b1;
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        start4  = 1'b0;
        start1  = 1'b0;
        rw      = 1'b0;
        addr    = 7'h00;
        wdata   = 8'h00;
        ack_en  = 1'b1;
        rd_mode = 1'b0;
        rd_byte = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_scl", scl4, 1);
        chk("reset_sda_oe", oe4, 0);
        chk("reset_busy", busy4, 0);
        chk("reset_done", done4, 0);
        chk("reset_ack_err", ack_err4, 0);
        chk("reset_rdata", rdata4, 8'h00);
        chk("sda_o_zero", sdao4, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Write 0x42/0xA5 with ACK; stray start at slot 5 (cycle 85) with altered inputs
        addr  = 7'h42;
        wdata = 8'hA5;
        rw    = 1'b0;
        run(1'b1, 85, -1);
        chk("write_done_cycle", done_e4, 320);
        chk("write_done_count", ndone4, 1);
        chk("write_bus_bits", cap[18:0], {8'h84, 1'b0, 8'hA5, 1'b0, 1'b0});
        chk("write_scl_rises", rise_cnt, 19);
        chk("write_ack_err", ack_err4, 0);
        chk("div1_done_cycle", done_e1, 80);
        chk("div1_done_count", ndone1, 1);
        n_tests++;
        assert (tr1 === tr4) else begin
            n_fail++;
            $error("FAIL div1_waveform_scaled: observed %h expected %h", tr1, tr4);
        end

        // No responder: NACK on address, STOP follows ACK1
        addr   = 7'h42;
        wdata  = 8'hA5;
        ack_en = 1'b0;
        run(1'b0, -1, -1);
        chk("nack_done_cycle", done_e4, 176);
        chk("nack_done_count", ndone4, 1);
        chk("nack_ack_err_held", ack_err4, 1);
        chk("nack_bus_bits", cap[9:0], {8'h84, 1'b1, 1'b0});
        chk("nack_scl_rises", rise_cnt, 10);

        // Reset at slot 10 aborts without done
        ack_en = 1'b1;
        run(1'b0, -1, 160);
        chk("abort_no_done", ndone4, 0);
        chk("abort_idle", busy4, 0);

        // rw=1: read when enabled, otherwise forced to a write
        addr = 7'h42;
        rw   = 1'b1;
`ifdef I2C_MASTER_READ_EN
        rd_mode = 1'b1;
        rd_byte = 8'h3C;
        wdata   = 8'h00;
        run(1'b0, -1, -1);
        chk("read_done_cycle", done_e4, 320);
        chk("read_bus_bits", cap[18:0], {8'h85, 1'b0, 8'h3C, 1'b1, 1'b0});
        chk("read_rdata", rdata4, 8'h3C);
`else
        rd_mode = 1'b0;
        wdata   = 8'h5A;
        run(1'b0, -1, -1);
        chk("rw_forced_done_cycle", done_e4, 320);
        chk("rw_forced_bus_bits", cap[18:0], {8'h84, 1'b0, 8'h5A, 1'b0, 1'b0});
        chk("rdata_tied_zero", rdata4, 8'h00);
`endif
        chk("post_reset_done_count", ndone4, 1);
        chk("post_reset_ack_err", ack_err4, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
